// File: rtl/memory_ram_pkg.sv
// ---------------------------------------------------------------------------
// memory_ram_pkg
//
// Shared constants and helpers for the memory_ram scratch store:
//   DEFAULT_WIDTH / DEFAULT_DEPTH  default data width and word count
//   RESET_BIT                      value every stored bit takes in reset
//   calc_aw()                      address width needed to cover a depth
// ---------------------------------------------------------------------------
package memory_ram_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Reset data is all zeros; replicated to WIDTH where it is used.
    localparam logic RESET_BIT = 1'b0;

    // Smallest width able to address 'depth' words (at least one bit).
    function automatic int unsigned calc_aw(input int unsigned depth);
        int unsigned aw;
        aw = 1;
        for (int unsigned k = 1; k < 32; k++) begin
            if ((32'd1 << aw) < depth) begin
                aw = k + 1;
            end
        end
        return aw;
    endfunction

endpackage

// File: rtl/memory_ram_core.sv
// ---------------------------------------------------------------------------
// memory_ram_core
//
// Storage array, write port and address-range checks for memory_ram.
// The read side is a plain combinational lookup; the parent registers it.
//
// Ports:
//   CLK      in   rising-edge clock
//   RESET    in   asynchronous active-low reset, clears every word
//   wr_en    in   write request (chip select already applied)
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address
//   rd_word  out  current contents at raddr, zero when raddr is out of range
//   wr_ok    out  (MEMORY_RAM_WR_BYPASS_EN only) a write is landing this cycle
//
// Configuration macro: MEMORY_RAM_WR_BYPASS_EN adds the wr_ok output.
// ---------------------------------------------------------------------------
module memory_ram_core
    import memory_ram_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW    = calc_aw(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
`ifdef MEMORY_RAM_WR_BYPASS_EN
    output logic             wr_ok,
`endif
    input  logic             wr_en,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rd_word
);

    // One extra bit so DEPTH itself is representable when it is a power of two.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             waddr_ok;
    logic             raddr_ok;

    // Non-power-of-two depths leave holes at the top of the address space.
    assign waddr_ok = ({1'b0, waddr} < DEPTH_LIM);
    assign raddr_ok = ({1'b0, raddr} < DEPTH_LIM);

`ifdef MEMORY_RAM_WR_BYPASS_EN
    assign wr_ok = wr_en && waddr_ok;
`endif

    // Reset wipes the whole array without waiting for a clock; writes to
    // holes in the address space are simply dropped.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= {WIDTH{RESET_BIT}};
            end
        end else if (wr_en && waddr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the array as it was before this edge's write (read-first).
    assign rd_word = raddr_ok ? mem[raddr] : {WIDTH{RESET_BIT}};

endmodule

// File: rtl/memory_ram.sv
// ---------------------------------------------------------------------------
// memory_ram
//
// Synchronous scratch RAM with independent write and read ports on one
// clock. One write and one read can be accepted every cycle; read data is
// registered with one cycle of latency and holds between reads.
//
// Ports:
//   CLK    in   rising-edge clock
//   RESET  in   asynchronous active-low reset (clears array and RDATA)
//   CS     in   chip select, gates both ports
//   WE     in   write enable
//   RE     in   read enable
//   WADDR  in   write address
//   WDATA  in   write data
//   RADDR  in   read address
//   RDATA  out  registered read data
//
// Configuration macro: MEMORY_RAM_WR_BYPASS_EN
//   defined   : same-address read+write returns WDATA (write-first)
//   undefined : same-address read+write returns old contents (read-first)
// ---------------------------------------------------------------------------
module memory_ram
    import memory_ram_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW    = calc_aw(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CS,
    input  logic             WE,
    input  logic             RE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] RDATA
);

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] rd_next;
`ifdef MEMORY_RAM_WR_BYPASS_EN
    logic             wr_ok;
`endif

    assign wr_en = CS && WE;
    assign rd_en = CS && RE;

    memory_ram_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .CLK     (CLK),
        .RESET   (RESET),
`ifdef MEMORY_RAM_WR_BYPASS_EN
        .wr_ok   (wr_ok),
`endif
        .wr_en   (wr_en),
        .waddr   (WADDR),
        .wdata   (WDATA),
        .raddr   (RADDR),
        .rd_word (rd_word)
    );

    // Value to capture on a read edge. The bypass only applies when the
    // write actually lands, so an out-of-range collision still reads zero.
    always_comb begin
        rd_next = rd_word;
`ifdef MEMORY_RAM_WR_BYPASS_EN
        if (wr_ok && (WADDR == RADDR)) begin
            rd_next = WDATA;
        end
`endif
    end

    // RDATA only moves on an enabled read; otherwise it holds.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RDATA <= {WIDTH{RESET_BIT}};
        end else if (rd_en) begin
            RDATA <= rd_next;
        end
    end

endmodule

// File: tb/tb_memory_ram.sv
// ---------------------------------------------------------------------------
// tb_memory_ram
//
// Directed bench for memory_ram (WIDTH=8, DEPTH=8). Inputs change on the
// falling edge, RDATA is checked 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_memory_ram;

    logic       CLK;
    logic       RESET;
    logic       CS;
    logic       WE;
    logic       RE;
    logic [2:0] WADDR;
    logic [7:0] WDATA;
    logic [2:0] RADDR;
    logic [7:0] RDATA;

    int total;
    int bad;

    memory_ram #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .CS    (CS),
        .WE    (WE),
        .RE    (RE),
        .WADDR (WADDR),
        .WDATA (WDATA),
        .RADDR (RADDR),
        .RDATA (RDATA)
    );

    // 10-unit clock period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive one cycle of inputs at the falling edge, then step just past
    // the following rising edge so RDATA has settled.
    task automatic applyStimulus(input logic cs, input logic we, input logic re,
                                 input logic [2:0] waddr, input logic [7:0] wdata,
                                 input logic [2:0] raddr);
        @(negedge CLK);
        CS    = cs;
        WE    = we;
        RE    = re;
        WADDR = waddr;
        WDATA = wdata;
        RADDR = raddr;
        @(posedge CLK);
        #1;
    endtask

    // Compare RDATA against a hand-computed value.
    task automatic checkOutput(input string tag, input logic [7:0] expected);
        total++;
        assert (RDATA === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%02h expected=%02h", tag, RDATA, expected);
        end
    endtask

    // Return all inputs to idle at a falling edge, optionally changing reset.
    task automatic idleAt(input logic rst);
        @(negedge CLK);
        RESET = rst;
        CS    = 1'b0;
        WE    = 1'b0;
        RE    = 1'b0;
        WADDR = 3'd0;
        WDATA = 8'h00;
        RADDR = 3'd0;
    endtask

    // Directed sequence with expected values worked out by hand.
    initial begin
        logic [7:0] expSame;
        total = 0;
        bad   = 0;
        RESET = 1'b0;
        CS    = 1'b0;
        WE    = 1'b0;
        RE    = 1'b0;
        WADDR = 3'd0;
        WDATA = 8'h00;
        RADDR = 3'd0;

        $display("[TB] start");

        // Writes and reads during reset are ignored; RDATA stays zero.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'(i), 8'($urandom_range(255)), 3'(i));
            checkOutput("reset_hold", 8'h00);
        end
        idleAt(1'b1);

        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'(i));
            checkOutput("post_reset_read", 8'h00);
        end

        // Fill with i*10 and read back.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 3'(i), 8'(i * 10), 3'd0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'(i));
            checkOutput("fill_readback", 8'(i * 10));
        end

        // Overwrite address 2.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 8'hAA, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 8'hBB, 3'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'd2);
        checkOutput("overwrite", 8'hBB);

        // Same-address simultaneous read and write.
`ifdef MEMORY_RAM_WR_BYPASS_EN
        expSame = 8'h77;
`else
        expSame = 8'hAA;
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd4, 8'hAA, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd4, 8'h77, 3'd4);
        checkOutput("same_addr_rw", expSame);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'd4);
        checkOutput("same_addr_next", 8'h77);

        // Different-address simultaneous read and write.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 8'h33, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd6, 8'h88, 3'd5);
        checkOutput("diff_addr_rw", 8'h33);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'd6);
        checkOutput("diff_addr_next", 8'h88);

        // CS=0 blocks both the write and the read.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'd7);
        checkOutput("read_addr7", 8'h46);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 8'h55, 3'd1);
        checkOutput("cs_low_hold", 8'h46);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'd0);
        checkOutput("cs_low_no_write", 8'h00);

        // RE=0 holds RDATA while writes continue.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'd5);
        checkOutput("read_addr5", 8'h33);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 8'h99, 3'(i + 1));
            checkOutput("re_low_hold", 8'h33);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'd5);
        checkOutput("write_during_re_low", 8'h99);

        // Asynchronous reset mid-operation clears RDATA without a clock edge.
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        checkOutput("async_reset_now", 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 8'hEE, 3'd5);
        checkOutput("async_reset_hold", 8'h00);
        idleAt(1'b1);

        // First edge after release performs a normal access.
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd3, 8'h5A, 3'd6);
        checkOutput("first_edge_read", 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'd3);
        checkOutput("first_edge_write", 8'h5A);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'd5);
        checkOutput("array_cleared", 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 3'd0);
        checkOutput("reset_write_ignored", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
